// File: rtl/axi_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package axi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        RDATA,
        WADDR,
        WDATA,
        WRESP
    } axi_arb_state_t;

    localparam logic [2:0] AXI_PROT_INST = 3'b100;
    localparam logic [2:0] AXI_PROT_DATA = 3'b000;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/axi_mem_arbiter_if.sv
// Cache request/response and AXI master signals of the memory arbiter.
interface axi_mem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 128
);
    localparam int STRB_W = DATA_W / 8;

    logic              ic_req_valid;
    logic              ic_req_ready;
    logic [ADDR_W-1:0] ic_req_addr;
    logic              ic_resp_valid;
    logic [DATA_W-1:0] ic_resp_data;
    logic              ic_resp_err;

    logic              dc_req_valid;
    logic              dc_req_ready;
    logic              dc_req_write;
    logic [ADDR_W-1:0] dc_req_addr;
    logic [DATA_W-1:0] dc_req_wdata;
    logic [STRB_W-1:0] dc_req_strb;
    logic              dc_resp_valid;
    logic [DATA_W-1:0] dc_resp_data;
    logic              dc_resp_err;

    logic              axi_readAddr_valid;
    logic              axi_readAddr_ready;
    logic [ADDR_W-1:0] axi_readAddr_bits_addr;
    logic [2:0]        axi_readAddr_bits_prot;
    logic              axi_readData_valid;
    logic              axi_readData_ready;
    logic [DATA_W-1:0] axi_readData_bits_data;
    logic [1:0]        axi_readData_bits_resp;
    logic              axi_writeAddr_valid;
    logic              axi_writeAddr_ready;
    logic [ADDR_W-1:0] axi_writeAddr_bits_addr;
    logic [2:0]        axi_writeAddr_bits_prot;
    logic              axi_writeData_valid;
    logic              axi_writeData_ready;
    logic [DATA_W-1:0] axi_writeData_bits_data;
    logic [STRB_W-1:0] axi_writeData_bits_strb;
    logic              axi_writeResp_valid;
    logic              axi_writeResp_ready;
    logic [1:0]        axi_writeResp_bits;

    modport master (
        input  ic_req_valid, ic_req_addr,
        output ic_req_ready, ic_resp_valid, ic_resp_data, ic_resp_err,
        input  dc_req_valid, dc_req_write, dc_req_addr, dc_req_wdata, dc_req_strb,
        output dc_req_ready, dc_resp_valid, dc_resp_data, dc_resp_err,
        output axi_readAddr_valid, axi_readAddr_bits_addr, axi_readAddr_bits_prot,
        input  axi_readAddr_ready,
        input  axi_readData_valid, axi_readData_bits_data, axi_readData_bits_resp,
        output axi_readData_ready,
        output axi_writeAddr_valid, axi_writeAddr_bits_addr, axi_writeAddr_bits_prot,
        input  axi_writeAddr_ready,
        output axi_writeData_valid, axi_writeData_bits_data, axi_writeData_bits_strb,
        input  axi_writeData_ready,
        input  axi_writeResp_valid, axi_writeResp_bits,
        output axi_writeResp_ready
    );

    modport slave (
        output ic_req_valid, ic_req_addr,
        input  ic_req_ready, ic_resp_valid, ic_resp_data, ic_resp_err,
        output dc_req_valid, dc_req_write, dc_req_addr, dc_req_wdata, dc_req_strb,
        input  dc_req_ready, dc_resp_valid, dc_resp_data, dc_resp_err,
        input  axi_readAddr_valid, axi_readAddr_bits_addr, axi_readAddr_bits_prot,
        output axi_readAddr_ready,
        output axi_readData_valid, axi_readData_bits_data, axi_readData_bits_resp,
        input  axi_readData_ready,
        input  axi_writeAddr_valid, axi_writeAddr_bits_addr, axi_writeAddr_bits_prot,
        output axi_writeAddr_ready,
        input  axi_writeData_valid, axi_writeData_bits_data, axi_writeData_bits_strb,
        output axi_writeData_ready,
        output axi_writeResp_valid, axi_writeResp_bits,
        input  axi_writeResp_ready
    );

endinterface

// File: rtl/axi_arb_grant.sv
// Grant selection between I-cache and D-cache. With AXI_ARB_RR_EN defined the
// contention winner alternates via a last-grant flop; otherwise D-cache wins.
module axi_arb_grant (
`ifdef AXI_ARB_RR_EN
    input  logic clk,
    input  logic rst,
`endif
    input  logic idle,
    input  logic ic_valid,
    input  logic dc_valid,
    output logic gnt_ic,
    output logic gnt_dc
);

`ifdef AXI_ARB_RR_EN
    logic last_dc_reg;

    // A grant is always accepted, since requesters hold valid until ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_dc_reg <= 1'b0;
        end else if (gnt_ic || gnt_dc) begin
            last_dc_reg <= gnt_dc;
        end
    end

    always_comb begin
        gnt_ic = 1'b0;
        gnt_dc = 1'b0;
        if (idle) begin
            if (ic_valid && dc_valid) begin
                gnt_dc = !last_dc_reg;
                gnt_ic = last_dc_reg;
            end else begin
                gnt_ic = ic_valid;
                gnt_dc = dc_valid;
            end
        end
    end
`else
    always_comb begin
        gnt_dc = idle && dc_valid;
        gnt_ic = idle && ic_valid && !dc_valid;
    end
`endif

endmodule

// File: rtl/axi_mem_arbiter.sv
// Serialises I-cache and D-cache line requests onto one AXI master port.
// Arbitration policy selected by AXI_ARB_RR_EN (round-robin) or fixed D-first.
module axi_mem_arbiter
    import axi_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    axi_mem_arbiter_if.master bus
);

    localparam int STRB_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-4){1'b1}}, 4'b0000};

    axi_arb_state_t    state_reg, state_next;
    logic              owner_dc_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [STRB_W-1:0] strb_reg;
    logic [2:0]        prot_reg;
    logic [DATA_W-1:0] ic_data_reg, dc_data_reg;
    logic              ic_err_reg, dc_err_reg, ic_valid_reg, dc_valid_reg;
    logic              gnt_ic, gnt_dc, idle, rd_done, wr_done;

    // Gating with rst keeps both readies low while reset is asserted.
    assign idle    = (state_reg == IDLE) && rst;
    assign rd_done = (state_reg == RDATA) && bus.axi_readData_valid;
    assign wr_done = (state_reg == WRESP) && bus.axi_writeResp_valid;

    axi_arb_grant u_grant (
`ifdef AXI_ARB_RR_EN
        .clk      (clk),
        .rst      (rst),
`endif
        .idle     (idle),
        .ic_valid (bus.ic_req_valid),
        .dc_valid (bus.dc_req_valid),
        .gnt_ic   (gnt_ic),
        .gnt_dc   (gnt_dc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next                 = state_reg;
        bus.axi_readAddr_valid     = 1'b0;
        bus.axi_readData_ready     = 1'b0;
        bus.axi_writeAddr_valid    = 1'b0;
        bus.axi_writeData_valid    = 1'b0;
        bus.axi_writeResp_ready    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (gnt_dc && bus.dc_req_write) begin
                    state_next = WADDR;
                end else if (gnt_ic || gnt_dc) begin
                    state_next = RADDR;
                end
            end
            RADDR: begin
                bus.axi_readAddr_valid = 1'b1;
                if (bus.axi_readAddr_ready) state_next = RDATA;
            end
            RDATA: begin
                bus.axi_readData_ready = 1'b1;
                if (bus.axi_readData_valid) state_next = IDLE;
            end
            WADDR: begin
                bus.axi_writeAddr_valid = 1'b1;
                if (bus.axi_writeAddr_ready) state_next = WDATA;
            end
            WDATA: begin
                bus.axi_writeData_valid = 1'b1;
                if (bus.axi_writeData_ready) state_next = WRESP;
            end
            WRESP: begin
                bus.axi_writeResp_ready = 1'b1;
                if (bus.axi_writeResp_valid) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_dc_reg <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            strb_reg     <= '0;
            prot_reg     <= '0;
            ic_data_reg  <= '0;
            dc_data_reg  <= '0;
            ic_err_reg   <= 1'b0;
            dc_err_reg   <= 1'b0;
            ic_valid_reg <= 1'b0;
            dc_valid_reg <= 1'b0;
        end else begin
            ic_valid_reg <= 1'b0;
            dc_valid_reg <= 1'b0;
            if (gnt_dc) begin
                owner_dc_reg <= 1'b1;
                addr_reg     <= bus.dc_req_addr & LINE_MASK;
                wdata_reg    <= bus.dc_req_wdata;
                strb_reg     <= bus.dc_req_strb;
                prot_reg     <= AXI_PROT_DATA;
            end else if (gnt_ic) begin
                owner_dc_reg <= 1'b0;
                addr_reg     <= bus.ic_req_addr & LINE_MASK;
                wdata_reg    <= '0;
                strb_reg     <= '0;
                prot_reg     <= AXI_PROT_INST;
            end
            if (rd_done && owner_dc_reg) begin
                dc_data_reg  <= bus.axi_readData_bits_data;
                dc_err_reg   <= (bus.axi_readData_bits_resp != AXI_RESP_OKAY);
                dc_valid_reg <= 1'b1;
            end else if (rd_done) begin
                ic_data_reg  <= bus.axi_readData_bits_data;
                ic_err_reg   <= (bus.axi_readData_bits_resp != AXI_RESP_OKAY);
                ic_valid_reg <= 1'b1;
            end
            if (wr_done) begin
                dc_data_reg  <= '0;
                dc_err_reg   <= (bus.axi_writeResp_bits != AXI_RESP_OKAY);
                dc_valid_reg <= 1'b1;
            end
        end
    end

    assign bus.ic_req_ready            = gnt_ic;
    assign bus.dc_req_ready            = gnt_dc;
    assign bus.ic_resp_valid           = ic_valid_reg;
    assign bus.ic_resp_data            = ic_data_reg;
    assign bus.ic_resp_err             = ic_err_reg;
    assign bus.dc_resp_valid           = dc_valid_reg;
    assign bus.dc_resp_data            = dc_data_reg;
    assign bus.dc_resp_err             = dc_err_reg;
    assign bus.axi_readAddr_bits_addr  = addr_reg;
    assign bus.axi_readAddr_bits_prot  = prot_reg;
    assign bus.axi_writeAddr_bits_addr = addr_reg;
    assign bus.axi_writeAddr_bits_prot = prot_reg;
    // Held from accept through WRESP: the memory model samples strb late.
    assign bus.axi_writeData_bits_data = wdata_reg;
    assign bus.axi_writeData_bits_strb = strb_reg;

endmodule

// File: doc/axi_mem_arbiter.md
# axi_mem_arbiter

- Two-master arbiter and AXI master for the core's memory path.
- Accepts 128-bit line requests from the instruction cache (read-only) and the data cache (read or write).
- Serialises them onto the single AXI port consumed by the simulation memory model.
- Returns each read line or write completion to the requester.

## Interface
- `ADDR_W`, 64: address width.
- `DATA_W`, 128: line/beat width; `STRB_W` = `DATA_W`/8.
- `clk`  in  1  core clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `ic_req_valid` in 1 / `ic_req_ready` out 1 / `ic_req_addr` in 64: I-cache line read request.
- `ic_resp_valid` out 1 / `ic_resp_data` out 128 / `ic_resp_err` out 1: I-cache response.
- `dc_req_valid` in 1 / `dc_req_ready` out 1 / `dc_req_write` in 1 / `dc_req_addr` in 64 / `dc_req_wdata` in 128 / `dc_req_strb` in 16: D-cache request.
- `dc_resp_valid` out 1 / `dc_resp_data` out 128 / `dc_resp_err` out 1: D-cache response (read data or write ack).
- `axi_readAddr_valid` out 1 / `axi_readAddr_ready` in 1 / `axi_readAddr_bits_addr` out 64 / `axi_readAddr_bits_prot` out 3.
- `axi_readData_valid` in 1 / `axi_readData_ready` out 1 / `axi_readData_bits_data` in 128 / `axi_readData_bits_resp` in 2.
- `axi_writeAddr_valid` out 1 / `axi_writeAddr_ready` in 1 / `axi_writeAddr_bits_addr` out 64 / `axi_writeAddr_bits_prot` out 3.
- `axi_writeData_valid` out 1 / `axi_writeData_ready` in 1 / `axi_writeData_bits_data` out 128 / `axi_writeData_bits_strb` out 16.
- `axi_writeResp_valid` in 1 / `axi_writeResp_ready` out 1 / `axi_writeResp_bits` in 2.

## Operation
- FSM states: IDLE, RADDR, RDATA, WADDR, WDATA, WRESP.
- Transaction capture:
  - `*_req_ready` = (state==IDLE) && granted master.
  - Accept latches owner, addr with low 4 bits forced to 0, wdata, strb and prot.
  - Prot is 3'b100 for I-cache and 3'b000 for D-cache.
- Next state after accept:
  - RADDR for a read.
  - WADDR for a D-cache write.
- Read path:
  - RADDR: `axi_readAddr_valid`=1; on `axi_readAddr_ready` go to RDATA.
  - RDATA: `axi_readData_ready`=1; on `axi_readData_valid` register data and err (resp!=0), go to IDLE.
- Write path:
  - WADDR: `axi_writeAddr_valid`=1; on ready go to WDATA.
  - WDATA: `axi_writeData_valid`=1; on ready go to WRESP.
  - WRESP: `axi_writeResp_ready`=1; on valid register err (bits!=0), go to IDLE.
- Write data and strb stay driven from the latched copy from accept until the WRESP handshake completes; the memory model samples strb during the response phase.
- Response: owner's `*_resp_valid` pulses exactly one cycle, the cycle after the final AXI handshake. Caches cannot backpressure it.
- Data and err hold until the next response to that owner. `dc_resp_data` is 0 for a write ack.
- Arbitration happens only in IDLE; a request with valid low is never granted. Requesters hold valid and payload until ready.

## Timing
- Reset (`rst`=0) immediately forces state=IDLE. All valid/ready outputs go to 0, and all data, addr and err outputs go to 0.
- A transaction in flight at reset is dropped and no response is issued.
- Read latency with zero-wait slave: accept (IDLE) → RADDR → RDATA → resp_valid. That is 1 + addr wait + data wait + 1 cycles; minimum 4 cycles from accept edge to resp_valid.
- Write minimum: accept → WADDR → WDATA → WRESP → resp_valid, 5 cycles.
- Back-to-back: a new request may be accepted in the same cycle the previous `*_resp_valid` is high.
- Simultaneous `ic_req_valid` and `dc_req_valid` in IDLE: resolved by the arbitration policy below. The loser keeps ready low.
- Only one AXI channel valid is ever high at a time. Read and write never overlap.

## Configuration
- `AXI_ARB_RR_EN` defined: round-robin.
  - One-bit last-grant register, reset to I-cache.
  - On contention, grant goes to the master not granted last; the register updates on each accept.
- `AXI_ARB_RR_EN` undefined: fixed priority, D-cache always wins contention. No last-grant register.

## Structure
- Shared package `axi_pkg` holds:
  - state enum `axi_arb_state_t`;
  - prot constants `AXI_PROT_INST`=3'b100 and `AXI_PROT_DATA`=3'b000;
  - resp constant `AXI_RESP_OKAY`=2'b00.
- One sub-module `axi_arb_grant`: combinational grant logic plus, under the macro, the last-grant flop.

## Test plan
- I-cache read at addr 0x8000_0008, slave returns 0x1111…_2222…, resp 0 → `axi_readAddr_bits_addr`=0x8000_0000, prot=3'b100; `ic_resp_valid` pulses once with that data; `ic_resp_err`=0.
- D-cache write at 0x8000_0010, strb 16'h00FF, slave delays writeResp 3 cycles → `axi_writeData_bits_data`/`axi_writeData_bits_strb` stay stable through WRESP; a single `dc_resp_valid` with err=0.
- Both masters valid every cycle for 4 grants → with `AXI_ARB_RR_EN` the order is D, I, D, I (last-grant reset to I-cache); without the macro it is D, D, D, D.
- Slave readData resp=2'b10 on a D-cache read → `dc_resp_err`=1 with the data passed through.
- Assert `rst` low while in RDATA → all AXI valid/ready outputs go to 0 immediately; no `*_resp_valid` after reset release; the next request completes normally.
